mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Successor to the split instruction ROM / data RAM arrangement.
- Lets the CPU's instruction-fetch port and data port share one single-port memory with configurable fixed read latency.
- Arbitrates the two ports with a valid/ready handshake, and exposes stall signals so the pipeline can freeze while its port waits.
- Sits between CPU and the unified memory in the top level.

Parameters:
ADDR_W, 32, address width of both ports and memory
DATA_W, 32, data width; must be a multiple of 8
SEL_W, DATA_W/8, byte-select width (derived, not overridden)
LATENCY, 1, cycles from mem_en high to mem_rdata valid; legal range 1..15
STARVE_MAX, 4, consecutive data grants tolerated while i_req pending before instruction port is forced; 0 = strict data priority

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
i_req  in  1  instruction fetch request, held until i_rdy
i_addr  in  ADDR_W  fetch address
i_rdy  out  1  one-cycle pulse: fetch complete, i_rdata valid
i_rdata  out  DATA_W  fetched word, held until next fetch completes
i_stall  out  1  i_req & ~i_rdy
d_req  in  1  data request, held until d_rdy
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data address
d_sel  in  SEL_W  byte enables for stores
d_wdata  in  DATA_W  store data
d_rdy  out  1  one-cycle pulse: access complete
d_rdata  out  DATA_W  load data, valid with d_rdy on loads; unchanged by stores
d_stall  out  1  d_req & ~d_rdy
mem_en  out  1  memory command strobe, one cycle per transaction
mem_we  out  1  memory write enable, qualified by mem_en
mem_addr  out  ADDR_W  memory address
mem_sel  out  SEL_W  byte enables; all ones on reads
mem_wdata  out  DATA_W  store data
mem_rdata  in  DATA_W  read data, valid exactly LATENCY cycles after mem_en

Behaviour:
- Reset (rst low, async): state IDLE; all mem_* outputs 0; i_rdy, d_rdy 0; i_rdata, d_rdata 0; wait and starve counters 0; current owner cleared.
- A memory response arriving after reset is ignored.
- Only one transaction is outstanding at a time; no pipelining.

FSM:
- IDLE:
  - Samples i_req and d_req.
  - Selects a winner and registers its command into mem_*, then moves to ISSUE.
  - With no request, stays in IDLE.
- ISSUE (1 cycle): mem_en = 1; wait counter loads LATENCY; goes to WAIT.
- WAIT:
  - mem_en = 0; mem_* other outputs hold their values.
  - Counter decrements each cycle.
  - In the cycle where mem_rdata is valid (LATENCY cycles after ISSUE), the read data is registered into the owner's rdata (loads and fetches only); then goes to RESP.
- RESP (1 cycle): owner's rdy = 1; returns to IDLE; no arbitration occurs in this cycle.

Timing:
- Request seen in IDLE at cycle 0 → mem_en in cycle 1 → rdy in cycle LATENCY+2.
- Minimum spacing between back-to-back transactions is LATENCY+3 cycles.

Arbitration:
- Only d_req: data wins.
- Only i_req: instruction wins.
- Both requests present:
  - If STARVE_MAX = 0 or starve counter < STARVE_MAX, data wins and the starve counter increments, saturating at STARVE_MAX.
  - Otherwise instruction wins.
- The starve counter clears on any instruction grant, and on any IDLE arbitration where i_req = 0.

Boundary conditions:
- A request deasserted before being granted is simply not served.
- A request deasserted after being granted still completes, and rdy still pulses.
- Stores: mem_we = 1, mem_sel = d_sel; mem_rdata is ignored; d_rdy pulses at the same latency as a load.
- d_sel = 0 on a store is legal: mem_en is still issued with mem_sel = 0 and d_rdy still pulses.
- A port's address and data are sampled only in the IDLE winning cycle; later changes have no effect.
- Reset asserted in ISSUE, WAIT or RESP aborts the transaction: no rdy pulse and counters cleared.

Decomposition:
- Shared define file: FSM state encodings (IDLE/ISSUE/WAIT/RESP), owner encoding (OWN_I/OWN_D), default widths aligned with the existing word/address bus macros.
- One natural sub-module: mem_arb_pick, a combinational winner select plus starve-counter update (i_req, d_req, starve count in → grant, next count out).
- The FSM, datapath registers and response capture stay in mem_arbiter.

Test Plan:
- LATENCY=1, i_req only, i_addr=0x100, memory returns 0xDEADBEEF → mem_en in cycle 1 with mem_addr=0x100; i_rdy and i_rdata=0xDEADBEEF in cycle 3; d_rdy stays 0.
- LATENCY=3, d store: d_addr=0x40, d_sel=4'b0011, d_wdata=0x12345678 → one-cycle mem_en with mem_we=1, mem_sel=0011; d_rdy in cycle 5; d_rdata unchanged.
- STARVE_MAX=2, i_req and d_req both held continuously → grant order D, D, I, D, D, I; i_rdy never pulses within one transaction of a d_rdy pulse.
- STARVE_MAX=0, i_req and d_req both held for 4 transactions → 4 data grants, i_stall held high throughout, zero i_rdy pulses.
- Reset (rst low) asserted in the WAIT state, LATENCY=4 → all outputs 0 immediately; the stale mem_rdata arriving after reset release produces no rdy; the next request is served normally.
- Back-to-back loads, d_req held, LATENCY=2 → d_rdy pulses exactly every 5 cycles; each d_rdata matches the mem_rdata of its own transaction.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared encodings and default widths for the unified-memory arbiter
package mem_arbiter_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  // Wide enough for the largest legal read latency (15).
  localparam int WAIT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arbState_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  function automatic int starveCntW(input int starveMax);
    return (starveMax < 2) ? 1 : $clog2(starveMax + 1);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - winner select between fetch and data ports with starvation guard
module mem_arb_pick
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 3
) (
  input  logic             iReq,
  input  logic             dReq,
  input  logic [CNT_W-1:0] starveCnt,
  output logic             grantValid,
  output owner_t           grantOwner,
  output logic [CNT_W-1:0] nextCnt
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(STARVE_MAX);

  logic underLimit;

  assign underLimit = (STARVE_MAX == 0) || (starveCnt < MAX_CNT);

  always_comb begin
    grantValid = 1'b0;
    grantOwner = OWN_I;
    nextCnt    = '0;
    if (dReq && (!iReq || underLimit)) begin
      grantValid = 1'b1;
      grantOwner = OWN_D;
      // Count only data wins that made a pending fetch wait; saturate at the limit.
      if (iReq && (starveCnt < MAX_CNT)) begin
        nextCnt = starveCnt + 1'b1;
      end
    end else if (iReq) begin
      grantValid = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one fixed-latency single-port memory between fetch and data ports
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  localparam int SEL_W     = DATA_W / 8,
  parameter int LATENCY    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_rdy,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [SEL_W-1:0]  d_sel,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_rdy,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [SEL_W-1:0]  mem_sel,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = starveCntW(STARVE_MAX);
  localparam logic [WAIT_W-1:0] LAT = WAIT_W'(LATENCY);

  arbState_t         state;
  arbState_t         stateNext;
  owner_t            owner;
  logic [WAIT_W-1:0] waitCnt;
  logic [CNT_W-1:0]  starveCnt;
  logic [CNT_W-1:0]  starveNext;
  logic              grantValid;
  owner_t            grantOwner;
  logic              lastBeat;

  mem_arb_pick #(
    .STARVE_MAX(STARVE_MAX),
    .CNT_W     (CNT_W)
  ) u_pick (
    .iReq      (i_req),
    .dReq      (d_req),
    .starveCnt (starveCnt),
    .grantValid(grantValid),
    .grantOwner(grantOwner),
    .nextCnt   (starveNext)
  );

  // Memory data is valid in the final WAIT cycle, when the countdown reaches one.
  assign lastBeat = (state == WAIT) && (waitCnt == WAIT_W'(1));
  assign i_stall  = i_req & ~i_rdy;
  assign d_stall  = d_req & ~d_rdy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (grantValid) stateNext = ISSUE;
      ISSUE:   stateNext = WAIT;
      WAIT:    if (lastBeat) stateNext = RESP;
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_sel   <= '0;
      mem_wdata <= '0;
      owner     <= OWN_I;
      waitCnt   <= '0;
      starveCnt <= '0;
      i_rdy     <= 1'b0;
      d_rdy     <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      mem_en <= 1'b0;
      i_rdy  <= 1'b0;
      d_rdy  <= 1'b0;
      case (state)
        IDLE: begin
          starveCnt <= starveNext;
          if (grantValid) begin
            mem_en <= 1'b1;
            owner  <= grantOwner;
            if (grantOwner == OWN_D) begin
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_sel   <= d_we ? d_sel : '1;
              mem_wdata <= d_wdata;
            end else begin
              mem_we    <= 1'b0;
              mem_addr  <= i_addr;
              mem_sel   <= '1;
              mem_wdata <= '0;
            end
          end
        end
        ISSUE: waitCnt <= LAT;
        WAIT: begin
          waitCnt <= waitCnt - 1'b1;
          if (lastBeat) begin
            if (owner == OWN_I) begin
              i_rdy   <= 1'b1;
              i_rdata <= mem_rdata;
            end else begin
              d_rdy <= 1'b1;
              if (!mem_we) d_rdata <= mem_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
